// File: rtl/ballot_ctrl.sv
// ballot_ctrl: debounces the officer arm button and four candidate buttons,
// opens one ballot per arm press, and delivers a single accepted vote as a
// one-hot level held across exactly one downstream sample tick.
module ballot_ctrl #(
    parameter logic [31:0] DEBOUNCE_CYCLES = 32'd1000000,
    parameter logic [31:0] TIMEOUT_CYCLES  = 32'd3000000000
) (
    input  logic       clock,
    input  logic       on_off,
    input  logic       btn_arm,
    input  logic       btn_p1,
    input  logic       btn_p2,
    input  logic       btn_p3,
    input  logic       btn_p4,
    input  logic       sample_tick,
    output logic       p1,
    output logic       p2,
    output logic       p3,
    output logic       p4,
    output logic       armed,
    output logic       fault,
    output logic [7:0] ballot_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_DELIVER = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    // Bit 0 is the arm button, bits 1..4 are candidates 1..4.
    logic [4:0] w_raw;
    logic [4:0] w_rise;
    logic [3:0] w_cand_deb;

    assign w_raw = {btn_p4, btn_p3, btn_p2, btn_p1, btn_arm};

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_cond
            logic        r_sync1;
            logic        r_sync2;
            logic        r_deb;
            logic        r_deb_d;
            logic [31:0] r_cnt;

            // Synchronise, debounce and remember the previous debounced level.
            always_ff @(posedge clock) begin
                if (on_off) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_deb   <= 1'b0;
                    r_deb_d <= 1'b0;
                    r_cnt   <= 32'd0;
                end else begin
                    r_sync1 <= w_raw[gi];
                    r_sync2 <= r_sync1;
                    r_deb_d <= r_deb;
                    if (r_sync2 == r_deb) begin
                        r_cnt <= 32'd0;
                    end else if (r_cnt == DEBOUNCE_CYCLES) begin
                        r_deb <= ~r_deb;
                        r_cnt <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
            end

            // The rise is seen in the cycle right after the debounced flip.
            assign w_rise[gi] = r_deb & ~r_deb_d;

            if (gi > 0) begin : g_cand
                assign w_cand_deb[gi-1] = r_deb;
            end
        end
    endgenerate

    state_t      r_state;
    logic [3:0]  r_p;
    logic        r_armed;
    logic        r_fault;
    logic [7:0]  r_count;
    logic [31:0] r_tmo;
    logic        r_first;

    logic [3:0]  w_cand_rise;
    logic [3:0]  w_cand_held;
    logic        w_single;
    logic        w_tmo_hit;

    assign w_cand_rise = w_rise[4:1];
    // Candidates already down before this cycle's rise.
    assign w_cand_held = w_cand_deb & ~w_cand_rise;
    assign w_single    = (w_cand_rise != 4'd0) &&
                         ((w_cand_rise & (w_cand_rise - 4'd1)) == 4'd0);
    assign w_tmo_hit   = (TIMEOUT_CYCLES != 32'd0) &&
                         ((r_tmo + 32'd1) == TIMEOUT_CYCLES);

    // Ballot FSM with all outputs registered.
    always_ff @(posedge clock) begin
        if (on_off) begin
            r_state <= S_IDLE;
            r_p     <= 4'd0;
            r_armed <= 1'b0;
            r_fault <= 1'b0;
            r_count <= 8'd0;
            r_tmo   <= 32'd0;
            r_first <= 1'b0;
        end else begin
            r_fault <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_p     <= 4'd0;
                    r_armed <= 1'b0;
                    if (w_rise[0]) begin
                        r_state <= S_ARMED;
                        r_armed <= 1'b1;
                        r_tmo   <= 32'd0;
                    end
                end
                S_ARMED: begin
                    // Counting continues through rejected multi-presses.
                    r_tmo <= r_tmo + 32'd1;
                    if (w_tmo_hit) begin
                        r_fault <= 1'b1;
                        r_armed <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_cand_rise != 4'd0) begin
                        if (w_single && (w_cand_held == 4'd0)) begin
                            r_p     <= w_cand_rise;
                            r_first <= 1'b1;
                            r_state <= S_DELIVER;
                        end else begin
                            r_fault <= 1'b1;
                        end
                    end
                end
                S_DELIVER: begin
                    // A tick in the entry cycle is skipped so the counter
                    // always gets a full cycle of the level before sampling.
                    r_first <= 1'b0;
                    if (sample_tick && !r_first) begin
                        r_p     <= 4'd0;
                        r_armed <= 1'b0;
                        r_state <= S_RELEASE;
                        if (r_count != 8'd255) begin
                            r_count <= r_count + 8'd1;
                        end
                    end
                end
                S_RELEASE: begin
                    if (w_cand_deb == 4'd0) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign p1           = r_p[0];
    assign p2           = r_p[1];
    assign p3           = r_p[2];
    assign p4           = r_p[3];
    assign armed        = r_armed;
    assign fault        = r_fault;
    assign ballot_count = r_count;

endmodule

// File: tb/tb_ballot_ctrl.sv
// Directed bench for ballot_ctrl with short debounce and timeout settings.
module tb_ballot_ctrl;

    logic       clock = 1'b0;
    logic       on_off;
    logic       btn_arm, btn_p1, btn_p2, btn_p3, btn_p4;
    logic       sample_tick;
    logic       p1, p2, p3, p4;
    logic       armed;
    logic       fault;
    logic [7:0] ballot_count;
    logic [3:0] p_vec;

    int n_asserts = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int tick_cnt  = 0;
    int fault_seen = 0;
    int multi_hot  = 0;

    assign p_vec = {p4, p3, p2, p1};

    ballot_ctrl #(
        .DEBOUNCE_CYCLES(32'd4),
        .TIMEOUT_CYCLES (32'd50)
    ) dut (
        .clock       (clock),
        .on_off      (on_off),
        .btn_arm     (btn_arm),
        .btn_p1      (btn_p1),
        .btn_p2      (btn_p2),
        .btn_p3      (btn_p3),
        .btn_p4      (btn_p4),
        .sample_tick (sample_tick),
        .p1          (p1),
        .p2          (p2),
        .p3          (p3),
        .p4          (p4),
        .armed       (armed),
        .fault       (fault),
        .ballot_count(ballot_count)
    );

    always #5 clock = ~clock;

    // Rising-edge counter used to time the ballot timeout.
    initial begin
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    // sample_tick: high for one cycle in every 20, changing just after posedge.
    initial begin
        sample_tick = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            tick_cnt    = (tick_cnt == 19) ? 0 : tick_cnt + 1;
            sample_tick = (tick_cnt == 19);
        end
    end

    // Background observation of fault pulses and one-hot violations.
    initial begin
        forever begin
            @(negedge clock);
            if (fault) fault_seen++;
            if ($countones(p_vec) > 1) multi_hot++;
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #1000000;
        $display("FAIL watchdog: observed no end of test, required finish before 1 ms");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_btn(input int idx, input logic v);
        case (idx)
            0: btn_arm = v;
            1: btn_p1  = v;
            2: btn_p2  = v;
            3: btn_p3  = v;
            default: btn_p4 = v;
        endcase
    endtask

    // Wait for candidate idx's output to fall; report whether the tick was
    // sampled on the edge that dropped it.
    task automatic wait_drop(input int idx, output logic dropped, output logic tick_prev);
        logic t;
        dropped   = 1'b0;
        tick_prev = 1'b0;
        for (int i = 0; i < 60; i++) begin
            t = sample_tick;
            step();
            if (p_vec[idx-1] == 1'b0) begin
                dropped   = 1'b1;
                tick_prev = t;
                break;
            end
        end
    endtask

    // Press arm and confirm armed appears on the eighth negedge.
    task automatic arm_ballot(input string tag);
        btn_arm = 1'b1;
        repeat (8) step();
        check(tag, armed, 1);
        repeat (2) step();
        btn_arm = 1'b0;
    endtask

    logic dropped, tick_prev, saw;
    int   armed_cyc;
    int   idx;
    int   bulk_miss = 0;

    initial begin
        on_off  = 1'b1;
        btn_arm = 1'b0; btn_p1 = 1'b0; btn_p2 = 1'b0; btn_p3 = 1'b0; btn_p4 = 1'b0;
        repeat (3) step();
        on_off = 1'b0;
        step();
        check("reset_armed", armed, 0);
        check("reset_p", p_vec, 0);
        check("reset_fault", fault, 0);
        check("reset_count", ballot_count, 0);

        // Clean vote with exact latency checks.
        btn_arm = 1'b1;
        repeat (7) step();
        check("arm_latency_early", armed, 0);
        step();
        check("arm_latency", armed, 1);
        repeat (2) step();
        btn_arm = 1'b0;
        btn_p2 = 1'b1;
        repeat (7) step();
        check("p2_latency_early", p_vec, 4'b0000);
        step();
        check("p2_latency", p_vec, 4'b0010);
        check("p2_armed", armed, 1);
        repeat (2) step();
        btn_p2 = 1'b0;
        wait_drop(2, dropped, tick_prev);
        check("p2_drop", dropped, 1);
        check("p2_drop_after_tick", tick_prev, 1);
        check("clean_count", ballot_count, 1);
        check("clean_armed_off", armed, 0);
        repeat (20) step();

        // Bounce rejection, then let the same ballot time out.
        btn_arm = 1'b1;
        repeat (8) step();
        check("arm_bounce", armed, 1);
        armed_cyc = cyc;
        repeat (2) step();
        btn_arm = 1'b0;
        for (int i = 0; i < 10; i++) begin
            btn_p3 = ~btn_p3;
            repeat (2) step();
        end
        repeat (10) step();
        check("bounce_p", p_vec, 0);
        check("bounce_armed", armed, 1);
        check("bounce_no_fault", fault_seen, 0);
        while (cyc < armed_cyc + 49) step();
        check("timeout_early_fault", fault, 0);
        check("timeout_early_armed", armed, 1);
        step();
        check("timeout_fault", fault, 1);
        check("timeout_armed", armed, 0);
        check("timeout_count", ballot_count, 1);
        step();
        check("timeout_fault_pulse", fault, 0);
        repeat (10) step();

        // Multi-press rejection keeps the ballot open.
        arm_ballot("arm_multi");
        btn_p1 = 1'b1;
        btn_p4 = 1'b1;
        repeat (7) step();
        check("multi_fault_early", fault, 0);
        step();
        check("multi_fault", fault, 1);
        check("multi_p", p_vec, 0);
        check("multi_armed", armed, 1);
        step();
        check("multi_fault_pulse", fault, 0);
        step();
        btn_p1 = 1'b0;
        btn_p4 = 1'b0;
        repeat (10) step();
        check("multi_still_armed", armed, 1);
        btn_p4 = 1'b1;
        repeat (8) step();
        check("multi_p4", p_vec, 4'b1000);
        repeat (2) step();
        btn_p4 = 1'b0;
        wait_drop(4, dropped, tick_prev);
        check("p4_drop", dropped, 1);
        check("p4_drop_after_tick", tick_prev, 1);
        check("multi_count", ballot_count, 2);
        repeat (20) step();

        // Held candidate blocks re-arming until released.
        arm_ballot("arm_held");
        btn_p1 = 1'b1;
        repeat (8) step();
        check("held_p1", p_vec, 4'b0001);
        wait_drop(1, dropped, tick_prev);
        check("held_drop", dropped, 1);
        check("held_count", ballot_count, 3);
        btn_arm = 1'b1;
        repeat (8) step();
        check("held_no_rearm", armed, 0);
        repeat (2) step();
        btn_arm = 1'b0;
        repeat (6) step();
        check("held_no_rearm_late", armed, 0);
        btn_p1 = 1'b0;
        repeat (12) step();
        check("held_arm_not_queued", armed, 0);
        btn_arm = 1'b1;
        repeat (7) step();
        check("rearm_early", armed, 0);
        step();
        check("rearm", armed, 1);
        repeat (2) step();
        btn_arm = 1'b0;

        // Reset while a vote is being delivered.
        btn_p2 = 1'b1;
        repeat (8) step();
        check("rst_mid_p2", p_vec, 4'b0010);
        on_off = 1'b1;
        step();
        check("rst_mid_p", p_vec, 0);
        check("rst_mid_armed", armed, 0);
        check("rst_mid_fault", fault, 0);
        check("rst_mid_count", ballot_count, 0);
        on_off = 1'b0;
        btn_p2 = 1'b0;
        repeat (15) step();

        // 256 complete ballots: count saturates at 255.
        for (int b = 0; b < 256; b++) begin
            idx = (b % 4) + 1;
            btn_arm = 1'b1;
            repeat (6) step();
            btn_arm = 1'b0;
            repeat (6) step();
            set_btn(idx, 1'b1);
            repeat (6) step();
            set_btn(idx, 1'b0);
            saw = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (p_vec[idx-1]) begin
                    saw = 1'b1;
                    break;
                end
                step();
            end
            if (!saw) bulk_miss++;
            wait_drop(idx, dropped, tick_prev);
            if (!dropped) bulk_miss++;
            if (b == 253) check("count_254", ballot_count, 254);
            if (b == 254) check("count_255", ballot_count, 255);
            if (b == 255) begin
                check("sat_vote_delivered", saw, 1);
                check("count_saturated", ballot_count, 255);
            end
            repeat (10) step();
        end
        check("bulk_all_delivered", bulk_miss, 0);
        check("one_hot_p", multi_hot, 0);
        check("fault_total", fault_seen, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
